// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM message sequencer.
//   - default widths for ROM address and data
//   - NUL terminator byte value
//   - FSM state encoding
package rom_seq_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [7:0] NUL_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/rom_msg_sequencer_byte_fifo.sv
// Synchronous byte FIFO with a registered head output.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             empties the FIFO (takes priority over push/pop)
//   push, din         write one entry
//   pop               consume the head entry (ignored when empty)
//   count             current number of stored entries
//   head_valid        registered, high while the FIFO holds data
//   head_data         registered head entry, stable until popped
module byte_fifo
  import rom_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  count_after_pop;
  logic [CNT_W-1:0]  count_n;
  logic              pop_ok;
  logic              push_ok;

  // Accepted operations and next occupancy
  always_comb begin
    pop_ok          = pop && (count != '0);
    push_ok         = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    rd_ptr_n        = rd_ptr + PTR_W'(pop_ok);
    count_after_pop = count - CNT_W'(pop_ok);
    count_n         = count_after_pop + CNT_W'(push_ok);
  end

  // Pointers, count and the registered head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr + PTR_W'(push_ok);
      count      <= count_n;
      head_valid <= (count_n != '0);
      // An entry pushed into an empty (or just-emptied) FIFO bypasses storage
      if (count_n == '0)
        head_data <= '0;
      else if (push_ok && (count_after_pop == '0))
        head_data <= din;
      else
        head_data <= mem[rd_ptr_n];
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= din;
  end

  // The credit scheme upstream must never push into a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && (count == CNT_W'(DEPTH)) && !pop_ok));

endmodule

// File: rtl/rom_msg_sequencer.sv
// ROM message sequencer: reads msg_len bytes from a synchronous text ROM
// starting at start_addr and streams them out on a valid/ready interface.
// Optional feature macro: ROM_SEQ_NUL_TERM_EN (a 0x00 byte ends the message).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, start_addr,    message request (sampled in IDLE only)
//   msg_len
//   abort                 cancel the current message, no done pulse
//   busy, done            status to the system controller
//   rom_addr, rom_q       ROM interface (1-cycle latency, registered address)
//   tx_data, tx_valid,    byte stream to the transmitter
//   tx_ready
module rom_msg_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  state_e            state_q;
  state_e            state_n;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  remaining;
  logic              rd_v1;      // address on rom_addr awaiting ROM sample
  logic              rd_v2;      // rom_q holds data for an issued read
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              issue;
  logic              accept;
  logic              flush;
  logic              nul_hit;
  logic              push;
  logic              pop;

  // Buffered plus in-flight bytes must fit in the buffer
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(rd_v1) + OCC_W'(rd_v2);
  assign credit_ok = (occupancy < OCC_W'(BUF_DEPTH));
  assign pop       = tx_valid && tx_ready;
  assign push      = rd_v2 && !nul_hit;

`ifdef ROM_SEQ_NUL_TERM_EN
  assign nul_hit = rd_v2 && (rom_q == DATA_W'(NUL_BYTE));
`else
  assign nul_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  // Next-state and per-cycle controls
  always_comb begin
    state_n = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          accept  = 1'b1;
          state_n = (msg_len == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (nul_hit) begin
          state_n = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (remaining == LEN_W'(1))
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (!rd_v1 && !rd_v2 && (fifo_count == '0)) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address generation, read pipeline tracking and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr <= '0;
      remaining <= '0;
      rom_addr  <= '0;
      rd_v1     <= 1'b0;
      rd_v2     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy  <= (state_n != IDLE);
      done  <= (state_q == FIN);
      rd_v1 <= issue;
      // A NUL hit discards the read issued right after it
      rd_v2 <= rd_v1 && !nul_hit && !flush;
      if (accept) begin
        next_addr <= start_addr;
        remaining <= msg_len;
      end else if (issue) begin
        rom_addr  <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  byte_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .din        (rom_q),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (tx_valid),
    .head_data  (tx_data)
  );

endmodule

// File: doc/rom_msg_sequencer.md
Name: rom_msg_sequencer

Overview:
- Controller for the synchronous text ROM (1-cycle read latency, registered address).
- Given a start address and a byte count, it fetches a message from the ROM and streams it as a valid/ready byte stream to the downstream transmitter.
- It absorbs ROM latency and downstream back-pressure with a small internal buffer, and reports busy/done to the system controller.

Parameters:
- ADDR_W, 5, ROM address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, ROM word width and stream byte width.
- BUF_DEPTH, 4, internal byte buffer depth; power of 2, minimum 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to send a message; sampled only in IDLE.
- start_addr  in  ADDR_W  first ROM address of the message, captured with start.
- msg_len  in  ADDR_W+1  byte count, captured with start; 0 is legal.
- abort  in  1  cancels the current message.
- busy  out  1  high from the cycle after start is accepted until done/abort completes.
- done  out  1  one-cycle pulse when the last byte is accepted downstream.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_q  in  DATA_W  ROM data, valid 2 edges after rom_addr is driven.
- tx_data  out  DATA_W  stream byte.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  downstream accepts when tx_valid && tx_ready at a rising edge.

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE; buffer is empty; in-flight count is 0.
  - busy=0, done=0, rom_addr=0, tx_valid=0, tx_data=0.
- FSM states:
  - IDLE: on start, capture start_addr/msg_len and set remaining=msg_len. Go to FETCH if msg_len≠0. If msg_len=0, go to FIN, which pulses done on the next cycle with no bytes sent.
  - FETCH: issue one address per cycle while remaining>0 and credit is available. On each issue, rom_addr<=next_addr, next_addr<=next_addr+1 (wraps 2^ADDR_W-1→0), remaining-=1. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until in-flight=0 and the buffer is empty with the last byte accepted, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Credit rule: issue only if buffer_count + in_flight < BUF_DEPTH. The buffer must never overflow; overflow is an assertion failure.
- Pipeline:
  - Address issued at edge E0 is sampled by the ROM at E1.
  - rom_q is captured into the buffer at E2, and tx_valid is high after E2.
  - With tx_ready held high, throughput is 1 byte/cycle after the first byte.
- Stream rules:
  - tx_data/tx_valid come from the buffer head, registered.
  - Once tx_valid is asserted, tx_data is held stable until accepted.
  - Bytes are emitted in address order, with no duplicates or drops.
- Simultaneous events:
  - A buffer push and pop in the same cycle leave the count unchanged.
  - start while busy (FETCH/DRAIN/FIN) is ignored.
  - start and abort together in IDLE: abort wins, start is ignored.
- abort in FETCH/DRAIN:
  - Next cycle: state=IDLE, buffer flushed, tx_valid=0, busy=0, no done pulse.
  - ROM data still in flight is discarded.
- Reset mid-message: immediate return to the reset values above; no done pulse.
- msg_len=2^ADDR_W: reads the full ROM once, wrapping back to the start address.

Optional Feature:
- Macro: ROM_SEQ_NUL_TERM_EN.
- When defined: a byte equal to 0 on rom_q terminates the message.
  - The NUL byte is not pushed to the buffer or emitted.
  - Further issuing stops, and later in-flight bytes are discarded.
  - done pulses once all earlier bytes are accepted.
  - msg_len remains an upper bound.
- When undefined: 0x00 is ordinary data, and exactly msg_len bytes are sent.

Decomposition:
- Shared package rom_seq_pkg:
  - FSM state enum (IDLE, FETCH, DRAIN, FIN).
  - Default widths ADDR_W=5, DATA_W=8.
  - Constant NUL_BYTE=8'h00.
- One sub-module: byte_fifo, a synchronous FIFO (BUF_DEPTH × DATA_W) with push, pop, flush, count, and registered head output.
- Address/credit logic and the FSM stay in rom_msg_sequencer.

Test Plan:
- ROM[i]=i+8'h40, start_addr=3, msg_len=5, tx_ready=1 → tx_data 43,44,45,46,47 on consecutive cycles. First tx_valid 3 edges after start; done pulses once; busy is low after done.
- Same message with tx_ready toggling 1,0,0,1,… → identical byte sequence. tx_data stable while stalled; buffer never exceeds 4; in-flight reads never exceed credit.
- start_addr=30, msg_len=4 (ADDR_W=5) → rom_addr 30,31,0,1; bytes 5E,5F,40,41.
- msg_len=0 → no tx_valid; done 2 cycles after start. start pulsed during busy → ignored, no extra bytes.
- abort after 2 bytes of msg_len=10 → tx_valid=0 and busy=0 next cycle, no done. A new start then sends the fresh message from its own start_addr.
- ROM_SEQ_NUL_TERM_EN, ROM 'H','i',00,'X', msg_len=4 → bytes 48,69 only, then done. Without the macro → 48,69,00,58.
